// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives the instruction memory
// address and feeds decode from a 2-entry {pc, instr} buffer over valid/ready.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        halt_o
);

    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] fpc;
    logic [31:0] head_pc, head_instr, tail_pc, tail_instr;
    logic [1:0]  count;
    logic        in_range, pop, push;

    assign in_range = (fpc < LIMIT);
    assign pop      = valid_o & ready_i;
    assign push     = (state == FETCH) & in_range & ((count != 2'd2) | pop) & ~redirect_i;

    // HALT is taken on the edge that drains the last in-range entry, so the
    // decision looks at the count after this edge's pop rather than before it.
    always_comb begin
        state_next = state;
        if (redirect_i) begin
            state_next = FETCH;
        end else begin
            case (state)
                IDLE:    state_next = FETCH;
                FETCH:   if (!in_range && (count == 2'd0 || (count == 2'd1 && pop)))
                             state_next = HALT;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            count      <= '0;
            head_pc    <= '0;
            head_instr <= '0;
            tail_pc    <= '0;
            tail_instr <= '0;
        end else begin
            state <= state_next;
            if (redirect_i) begin
                count <= '0;
                fpc   <= {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (push) fpc <= fpc + 32'd4;
                case ({push, pop})
                    2'b01: begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        count      <= count - 2'd1;
                    end
                    2'b10: begin
                        if (count == 2'd0) begin
                            head_pc    <= fpc;
                            head_instr <= mem_instr_i;
                        end else begin
                            tail_pc    <= fpc;
                            tail_instr <= mem_instr_i;
                        end
                        count <= count + 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head_pc    <= fpc;
                            head_instr <= mem_instr_i;
                        end else begin
                            head_pc    <= tail_pc;
                            head_instr <= tail_instr;
                            tail_pc    <= fpc;
                            tail_instr <= mem_instr_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr_o = fpc;
    assign valid_o    = (count != 2'd0);
    assign instr_o    = valid_o ? head_instr : '0;
    assign pc_o       = valid_o ? head_pc : '0;
    assign halt_o     = (state == HALT);

endmodule
